// File: rtl/data_memory_mc_if.sv
// Request/response bundle between the MEM stage and data_memory_mc.
// The pipeline side is the master; the memory is the slave.
interface data_memory_mc_if;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;
  logic        mem_read_enable_in;
  logic        mem_write_enable_in;
  logic        byte_mode_in;
  logic [31:0] result_out;
  logic        stall_out;
  logic        ready_out;
  logic        fault_out;

  modport master (
    output alu_res_in, val_rm_in, mem_read_enable_in, mem_write_enable_in, byte_mode_in,
    input  result_out, stall_out, ready_out, fault_out
  );

  modport slave (
    input  alu_res_in, val_rm_in, mem_read_enable_in, mem_write_enable_in, byte_mode_in,
    output result_out, stall_out, ready_out, fault_out
  );
endinterface

// File: rtl/data_memory_mc.sv
// Multi-cycle word/byte data memory with stall handshake and access fault.
// LATENCY=0 degenerates to a combinational-read, edge-write memory.
module data_memory_mc #(
  parameter int unsigned WORD_COUNT = 64,
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_memory_mc_if.slave bus
);
  localparam int unsigned AW = (WORD_COUNT > 2) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  logic [31:0] mem_q [WORD_COUNT];

  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          fault;
  logic          wr_req, rd_req, req;
  logic [31:0]   rd_word, rd_data, wr_word;
  logic          mem_we;

  assign wr_req   = bus.mem_write_enable_in;
  assign rd_req   = bus.mem_read_enable_in;
  assign req      = wr_req | rd_req;
  assign offset   = bus.alu_res_in - BASE_ADDR;
  assign lane     = offset[1:0];
  assign word_idx = offset[AW+1:2];
  assign rd_word  = mem_q[word_idx];

  // Underflow is caught by the explicit compare; the wrapped offset alone would look huge but valid-aligned.
  assign fault = (bus.alu_res_in < BASE_ADDR) ||
                 (offset >= 32'(4 * WORD_COUNT)) ||
                 (!bus.byte_mode_in && lane != 2'd0);

  always_comb begin
    rd_data = 32'd0;
    wr_word = rd_word;
    if (bus.byte_mode_in) begin
      rd_data[7:0]           = rd_word[lane*8 +: 8];
      wr_word[lane*8 +: 8]   = bus.val_rm_in[7:0];
    end else begin
      rd_data = rd_word;
      wr_word = bus.val_rm_in;
    end
    if (fault) rd_data = 32'd0;
  end

  // NOTE: storage has no reset on purpose; only the control path is cleared by rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= wr_word;
  end

  generate
    if (LATENCY == 0) begin : g_single
      assign mem_we         = wr_req && !fault && !rst;
      assign bus.stall_out  = 1'b0;
      assign bus.ready_out  = 1'b0;
      assign bus.result_out = rd_req ? rd_data : 32'd0;
      assign bus.fault_out  = req && fault;
    end else begin : g_multi
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [31:0]   result_q, result_d;
      logic          fault_q, fault_d;
      logic          commit;

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        fault_d  = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
          IDLE: if (req) begin
            if (LATENCY == 1) begin
              state_d = DONE;
              commit  = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CW'(LATENCY - 1);
            end
          end
          WAIT: if (cnt_q == CW'(1)) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
        // Everything architecturally visible happens on the edge entering DONE.
        if (commit) begin
          fault_d = fault;
          if (rd_req && !wr_req) result_d = rd_data;
        end
      end

      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          result_q <= 32'd0;
          fault_q  <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          result_q <= result_d;
          fault_q  <= fault_d;
        end
      end

      assign mem_we         = commit && wr_req && !fault && !rst;
      assign bus.stall_out  = (state_q == IDLE && req) || (state_q == WAIT);
      assign bus.ready_out  = (state_q == DONE);
      assign bus.result_out = result_q;
      assign bus.fault_out  = fault_q;
    end
  endgenerate
endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_data_memory_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_memory_mc_if bus_l2 ();
  data_memory_mc_if bus_l0 ();

  data_memory_mc #(.WORD_COUNT(64), .BASE_ADDR(32'd1024), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .bus(bus_l2.slave)
  );
  data_memory_mc #(.WORD_COUNT(64), .BASE_ADDR(32'd1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst), .bus(bus_l0.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_l2();
    bus_l2.mem_read_enable_in  = 1'b0;
    bus_l2.mem_write_enable_in = 1'b0;
    bus_l2.byte_mode_in        = 1'b0;
    bus_l2.alu_res_in          = 32'd0;
    bus_l2.val_rm_in           = 32'd0;
  endtask

  // Called just after a rising edge; returns just after the DONE->IDLE edge.
  task automatic access(input string tag, input bit wr, input bit rd, input bit bm,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_res, input bit exp_fault);
    int stalls = 0;
    bit done   = 1'b0;
    bus_l2.alu_res_in          = addr;
    bus_l2.val_rm_in           = data;
    bus_l2.mem_write_enable_in = wr;
    bus_l2.mem_read_enable_in  = rd;
    bus_l2.byte_mode_in        = bm;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (bus_l2.ready_out) begin
        done = 1'b1;
        check({tag, " stall_in_done"}, bus_l2.stall_out, 1'b0);
        check({tag, " result"}, bus_l2.result_out, exp_res);
        check({tag, " fault"}, bus_l2.fault_out, exp_fault);
      end else if (bus_l2.stall_out) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " completed"}, done, 1'b1);
    check({tag, " stall_cycles"}, stalls, 2);
    idle_l2();
  endtask

  initial begin
    idle_l2();
    bus_l0.mem_read_enable_in  = 1'b0;
    bus_l0.mem_write_enable_in = 1'b0;
    bus_l0.byte_mode_in        = 1'b0;
    bus_l0.alu_res_in          = 32'd0;
    bus_l0.val_rm_in           = 32'd0;

    #12;
    check("rst result", bus_l2.result_out, 32'd0);
    check("rst stall",  bus_l2.stall_out, 1'b0);
    check("rst ready",  bus_l2.ready_out, 1'b0);
    check("rst fault",  bus_l2.fault_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word and byte accesses; writes leave result_out untouched.
    access("wr_deadbeef",  1, 0, 0, 32'd1028, 32'hDEADBEEF, 32'h0000_0000, 0);
    access("rd_1028",      0, 1, 0, 32'd1028, 32'h0,        32'hDEADBEEF, 0);
    access("wrb_1029",     1, 0, 1, 32'd1029, 32'hFFFF_FFAB, 32'hDEADBEEF, 0);
    access("rd_1028_lane", 0, 1, 0, 32'd1028, 32'h0,        32'hDEADABEF, 0);
    access("rdb_1031",     0, 1, 1, 32'd1031, 32'h0,        32'h0000_00DE, 0);

    // Last word, then faults around it.
    access("wr_last",      1, 0, 0, 32'd1276, 32'h22222222, 32'h0000_00DE, 0);
    access("wr_oor",       1, 0, 0, 32'd1280, 32'h11111111, 32'h0000_00DE, 1);
    access("rd_below",     0, 1, 0, 32'd1020, 32'h0,        32'h0000_0000, 1);
    access("rd_misalign",  0, 1, 0, 32'd1030, 32'h0,        32'h0000_0000, 1);
    access("rd_last",      0, 1, 0, 32'd1276, 32'h0,        32'h22222222, 0);

    // Both enables: a write, result_out keeps its value.
    access("rdwr_1032",    1, 1, 0, 32'd1032, 32'h5,        32'h22222222, 0);
    access("rd_1032",      0, 1, 0, 32'd1032, 32'h0,        32'h0000_0005, 0);

    // Reset during WAIT discards the pending write.
    access("wr_cafe",      1, 0, 0, 32'd1036, 32'hCAFE0000, 32'h0000_0005, 0);
    bus_l2.alu_res_in          = 32'd1036;
    bus_l2.val_rm_in           = 32'h12345678;
    bus_l2.mem_write_enable_in = 1'b1;
    @(negedge clk);
    check("abort stall_idle", bus_l2.stall_out, 1'b1);
    @(negedge clk);
    check("abort stall_wait", bus_l2.stall_out, 1'b1);
    rst = 1'b1;
    idle_l2();
    #1;
    check("abort stall",  bus_l2.stall_out, 1'b0);
    check("abort ready",  bus_l2.ready_out, 1'b0);
    check("abort result", bus_l2.result_out, 32'd0);
    check("abort fault",  bus_l2.fault_out, 1'b0);
    @(posedge clk);
    #1;
    check("abort held ready", bus_l2.ready_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access("rd_1036",      0, 1, 0, 32'd1036, 32'h0,        32'hCAFE0000, 0);

    // Single-cycle instance.
    bus_l0.alu_res_in          = 32'd1028;
    bus_l0.val_rm_in           = 32'h77;
    bus_l0.mem_write_enable_in = 1'b1;
    #1;
    check("l0 wr stall", bus_l0.stall_out, 1'b0);
    check("l0 wr result", bus_l0.result_out, 32'd0);
    @(posedge clk);
    #1;
    bus_l0.mem_write_enable_in = 1'b0;
    bus_l0.mem_read_enable_in  = 1'b1;
    #1;
    check("l0 rd result", bus_l0.result_out, 32'h77);
    check("l0 rd stall",  bus_l0.stall_out, 1'b0);
    check("l0 rd ready",  bus_l0.ready_out, 1'b0);
    check("l0 rd fault",  bus_l0.fault_out, 1'b0);
    bus_l0.alu_res_in = 32'd1020;
    #1;
    check("l0 below fault",  bus_l0.fault_out, 1'b1);
    check("l0 below result", bus_l0.result_out, 32'd0);
    bus_l0.mem_read_enable_in = 1'b0;
    bus_l0.alu_res_in         = 32'd1028;
    #1;
    check("l0 idle result", bus_l0.result_out, 32'd0);
    check("l0 idle fault",  bus_l0.fault_out, 1'b0);
    @(posedge clk);
    #1;
    check("l0 idle stall", bus_l0.stall_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
